// File: rtl/mem_arbiter_if.sv
// Request/fill/memory bundle between the two cache miss handlers, the MEM-stage store
// path and the shared main memory. The slave modport is the arbiter's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WORD_W = 3
) ();
  // I-cache fill port
  logic              ic_miss_req;
  logic [ADDR_W-1:0] ic_miss_addr;
  logic              ic_fill_valid;
  logic              ic_fill_done;
  // D-cache fill and write-through port
  logic              dc_miss_req;
  logic [ADDR_W-1:0] dc_miss_addr;
  logic              dc_fill_valid;
  logic              dc_fill_done;
  logic              dc_wr_req;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [DATA_W-1:0] dc_wr_data;
  logic              dc_wr_ack;
  // Shared fill return
  logic [DATA_W-1:0] fill_data;
  logic [WORD_W-1:0] fill_word;
  // Main memory
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              busy;

  modport slave (
    input  ic_miss_req, ic_miss_addr, dc_miss_req, dc_miss_addr,
    input  dc_wr_req, dc_wr_addr, dc_wr_data, mem_rdata, mem_rvalid,
    output ic_fill_valid, ic_fill_done, dc_fill_valid, dc_fill_done, dc_wr_ack,
    output fill_data, fill_word, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output ic_miss_req, ic_miss_addr, dc_miss_req, dc_miss_addr,
    output dc_wr_req, dc_wr_addr, dc_wr_data, mem_rdata, mem_rvalid,
    input  ic_fill_valid, ic_fill_done, dc_fill_valid, dc_fill_done, dc_wr_ack,
    input  fill_data, fill_word, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: D-side write-through stores and I/D block fills as pipelined
// reads. Define MEM_ARB_RR_EN for round-robin between the two fill requesters.
module mem_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16
) (
  input logic            clk,
  input logic            rst,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned WordW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned OffW  = WordW + 1;  // byte offset bits within a block

  localparam logic [WordW:0]   IssueEnd = (WordW + 1)'(WORDS_PER_BLOCK);
  localparam logic [WordW-1:0] LastWord = WordW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StFillI, StFillD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [WordW:0]    issue_cnt_q, issue_cnt_d;
  logic [WordW-1:0]  ret_cnt_q, ret_cnt_d;
  logic              grant_dc_fill;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;  // 1: last fill went to the D side

  assign grant_dc_fill = bus.dc_miss_req && (!bus.ic_miss_req || !last_grant_q);
`else
  assign grant_dc_fill = bus.dc_miss_req;
`endif

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OffW], {OffW{1'b0}}};
  endfunction

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    bus.mem_en        = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.dc_wr_ack     = 1'b0;
    bus.ic_fill_valid = 1'b0;
    bus.ic_fill_done  = 1'b0;
    bus.dc_fill_valid = 1'b0;
    bus.dc_fill_done  = 1'b0;
    bus.fill_data     = '0;
    bus.fill_word     = '0;
    bus.busy          = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        // Stray returns here are dropped: nothing is outstanding.
        if (bus.dc_wr_req) begin
          state_d   = StWrite;
          wr_addr_d = bus.dc_wr_addr;
          wr_data_d = bus.dc_wr_data;
        end else if (grant_dc_fill) begin
          state_d     = StFillD;
          base_d      = block_base(bus.dc_miss_addr);
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
`ifdef MEM_ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (bus.ic_miss_req) begin
          state_d     = StFillI;
          base_d      = block_base(bus.ic_miss_addr);
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
`ifdef MEM_ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end

      StWrite: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = wr_addr_q;
        bus.mem_wdata = wr_data_q;
        bus.dc_wr_ack = 1'b1;
        state_d       = StIdle;
      end

      StFillI, StFillD: begin
        if (issue_cnt_q < IssueEnd) begin
          bus.mem_en   = 1'b1;
          // Base is block aligned, so the offset is OR-ed in and can never carry out.
          bus.mem_addr = base_q | ADDR_W'({issue_cnt_q[WordW-1:0], 1'b0});
          issue_cnt_d  = issue_cnt_q + (WordW + 1)'(1);
        end
        if (bus.mem_rvalid) begin
          bus.fill_data = bus.mem_rdata;
          bus.fill_word = ret_cnt_q;
          ret_cnt_d     = ret_cnt_q + WordW'(1);
          if (state_q == StFillI) bus.ic_fill_valid = 1'b1;
          else                    bus.dc_fill_valid = 1'b1;
          if (ret_cnt_q == LastWord) begin
            if (state_q == StFillI) bus.ic_fill_done = 1'b1;
            else                    bus.dc_fill_done = 1'b1;
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
